// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - two requester ports plus the shared register-file port
interface regfile_arbiter_if #(
    parameter int R_ADDR_WIDTH = 2
);
    logic                    a_req;
    logic                    a_we;
    logic [R_ADDR_WIDTH-1:0] a_reg;
    logic [31:0]             a_wdata;
    logic                    a_gnt;
    logic                    a_rvalid;
    logic [31:0]             a_rdata;

    logic                    b_req;
    logic                    b_we;
    logic [R_ADDR_WIDTH-1:0] b_reg;
    logic [31:0]             b_wdata;
    logic                    b_gnt;
    logic                    b_rvalid;
    logic [31:0]             b_rdata;

    logic                    o_rd;
    logic [R_ADDR_WIDTH-1:0] o_rreg;
    logic [31:0]             i_rdata;
    logic                    o_wr;
    logic [R_ADDR_WIDTH-1:0] o_wreg;
    logic [31:0]             o_wdata;

    // Arbiter side.
    modport slave (
        input  a_req, a_we, a_reg, a_wdata,
        input  b_req, b_we, b_reg, b_wdata,
        input  i_rdata,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output o_rd, o_rreg, o_wr, o_wreg, o_wdata
    );

    // Requesters and register file side.
    modport master (
        output a_req, a_we, a_reg, a_wdata,
        output b_req, b_we, b_reg, b_wdata,
        output i_rdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  o_rd, o_rreg, o_wr, o_wreg, o_wdata
    );
endinterface

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin arbiter sharing one register-file port between two requesters
// Define REGARB_FIXED_PRIORITY_EN to make port A win every contention.
module regfile_arbiter #(
    parameter int R_ADDR_WIDTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_b_q, last_b_d;
    logic                    win_b_q, win_b_d;
    logic                    a_gnt_q, a_gnt_d;
    logic                    b_gnt_q, b_gnt_d;
    logic                    a_rvalid_q, a_rvalid_d;
    logic                    b_rvalid_q, b_rvalid_d;
    logic [31:0]             a_rdata_q, a_rdata_d;
    logic [31:0]             b_rdata_q, b_rdata_d;
    logic                    o_rd_q, o_rd_d;
    logic                    o_wr_q, o_wr_d;
    logic [R_ADDR_WIDTH-1:0] o_rreg_q, o_rreg_d;
    logic [R_ADDR_WIDTH-1:0] o_wreg_q, o_wreg_d;
    logic [31:0]             o_wdata_q, o_wdata_d;

    logic                    pick_a;
    logic                    pick_b;
    logic                    sel_we;
    logic [R_ADDR_WIDTH-1:0] sel_reg;
    logic [31:0]             sel_wdata;

    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        win_b_d    = win_b_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        o_rd_d     = 1'b0;
        o_wr_d     = 1'b0;
        o_rreg_d   = o_rreg_q;
        o_wreg_d   = o_wreg_q;
        o_wdata_d  = o_wdata_q;
        pick_a     = 1'b0;
        pick_b     = 1'b0;
        sel_we     = 1'b0;
        sel_reg    = '0;
        sel_wdata  = '0;

        case (state_q)
            IDLE: begin
`ifdef REGARB_FIXED_PRIORITY_EN
                pick_a = bus.a_req;
`else
                // A wins contention only if B took the previous grant.
                pick_a = bus.a_req && (!bus.b_req || last_b_q);
`endif
                pick_b = bus.b_req && !pick_a;
                if (pick_b) begin
                    sel_we    = bus.b_we;
                    sel_reg   = bus.b_reg;
                    sel_wdata = bus.b_wdata;
                end else begin
                    sel_we    = bus.a_we;
                    sel_reg   = bus.a_reg;
                    sel_wdata = bus.a_wdata;
                end
                if (pick_a || pick_b) begin
                    state_d  = ISSUE;
                    last_b_d = pick_b;
                    win_b_d  = pick_b;
                    a_gnt_d  = pick_a;
                    b_gnt_d  = pick_b;
                    if (sel_we) begin
                        o_wr_d    = 1'b1;
                        o_wreg_d  = sel_reg;
                        o_wdata_d = sel_wdata;
                    end else begin
                        o_rd_d    = 1'b1;
                        o_rreg_d  = sel_reg;
                    end
                end
            end
            ISSUE: begin
                state_d = IDLE;
                // i_rdata is valid while the read strobe is out; return it next cycle.
                if (o_rd_q) begin
                    if (win_b_q) begin
                        b_rvalid_d = 1'b1;
                        b_rdata_d  = bus.i_rdata;
                    end else begin
                        a_rvalid_d = 1'b1;
                        a_rdata_d  = bus.i_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            win_b_q    <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            o_rd_q     <= 1'b0;
            o_wr_q     <= 1'b0;
            o_rreg_q   <= '0;
            o_wreg_q   <= '0;
            o_wdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            win_b_q    <= win_b_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            o_rd_q     <= o_rd_d;
            o_wr_q     <= o_wr_d;
            o_rreg_q   <= o_rreg_d;
            o_wreg_q   <= o_wreg_d;
            o_wdata_q  <= o_wdata_d;
        end
    end

    assign bus.a_gnt    = a_gnt_q;
    assign bus.b_gnt    = b_gnt_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.o_rd     = o_rd_q;
    assign bus.o_wr     = o_wr_q;
    assign bus.o_rreg   = o_rreg_q;
    assign bus.o_wreg   = o_wreg_q;
    assign bus.o_wdata  = o_wdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - self-checking bench for regfile_arbiter with a register-file model
module tb_regfile_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic        rd_force;
    logic [31:0] rd_force_val;
    logic [31:0] mem [4];

    regfile_arbiter_if #(.R_ADDR_WIDTH(2)) bus();

    regfile_arbiter #(.R_ADDR_WIDTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: sees the strobes mid-cycle, answers reads with stored data.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        end else if (bus.o_wr) begin
            mem[bus.o_wreg] = bus.o_wdata;
        end
        if (rd_force)      bus.i_rdata = rd_force_val;
        else if (bus.o_rd) bus.i_rdata = mem[bus.o_rreg];
        else               bus.i_rdata = $urandom();
    end

    task automatic clear_inputs();
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_reg = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_reg = '0; bus.b_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.o_rd, bus.o_wr} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes got %b exp 000000",
                     {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.o_rd, bus.o_wr});
        end
        checks++;
        if ({bus.a_rdata, bus.b_rdata, bus.o_rreg, bus.o_wreg, bus.o_wdata} !== 100'b0) begin
            failures++;
            $display("FAIL reset_data got a_rdata=%h b_rdata=%h rreg=%h wreg=%h wdata=%h exp all 0",
                     bus.a_rdata, bus.b_rdata, bus.o_rreg, bus.o_wreg, bus.o_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_reg = 2'd2; bus.a_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({bus.o_wr, bus.o_rd, bus.a_gnt, bus.b_gnt} !== 4'b1010) begin
            failures++;
            $display("FAIL write_strobes got wr/rd/agnt/bgnt=%b exp 1010",
                     {bus.o_wr, bus.o_rd, bus.a_gnt, bus.b_gnt});
        end
        checks++;
        if ({bus.o_wreg, bus.o_wdata} !== {2'd2, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL write_data got wreg=%0d wdata=%h exp 2 deadbeef", bus.o_wreg, bus.o_wdata);
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({bus.o_wr, bus.a_gnt, bus.a_rvalid} !== 3'b000) begin
            failures++;
            $display("FAIL write_after got wr/gnt/rvalid=%b exp 000", {bus.o_wr, bus.a_gnt, bus.a_rvalid});
        end
    endtask

    task automatic test_single_read();
        do_reset();
        rd_force = 1'b1;
        rd_force_val = 32'h12345678;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_reg = 2'd3;
        @(negedge clk);
        checks++;
        if ({bus.o_rd, bus.o_wr, bus.b_gnt, bus.a_gnt, bus.o_rreg} !== {4'b1010, 2'd3}) begin
            failures++;
            $display("FAIL read_issue got rd/wr/bgnt/agnt=%b rreg=%0d exp 1010 3",
                     {bus.o_rd, bus.o_wr, bus.b_gnt, bus.a_gnt}, bus.o_rreg);
        end
        clear_inputs();
        @(negedge clk);
        rd_force = 1'b0;
        checks++;
        if ({bus.b_rvalid, bus.a_rvalid, bus.b_rdata, bus.a_rdata} !== {2'b10, 32'h12345678, 32'h0}) begin
            failures++;
            $display("FAIL read_return got brv=%b arv=%b b_rdata=%h a_rdata=%h exp 1 0 12345678 0",
                     bus.b_rvalid, bus.a_rvalid, bus.b_rdata, bus.a_rdata);
        end
        @(negedge clk);
        checks++;
        if ({bus.b_rvalid, bus.b_rdata} !== {1'b0, 32'h12345678}) begin
            failures++;
            $display("FAIL read_hold got brv=%b b_rdata=%h exp 0 12345678", bus.b_rvalid, bus.b_rdata);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        logic       prev_strobe;
        do_reset();
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_reg = 2'd0; bus.a_wdata = 32'hA;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_reg = 2'd1; bus.b_wdata = 32'hB;
        prev_strobe = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
`ifdef REGARB_FIXED_PRIORITY_EN
            exp_g = (cyc % 2 == 1) ? 2'b01 : 2'b00;
`else
            exp_g = (cyc % 4 == 1) ? 2'b01 : ((cyc % 4 == 3) ? 2'b10 : 2'b00);
`endif
            checks++;
            if ({bus.b_gnt, bus.a_gnt} !== exp_g) begin
                failures++;
                $display("FAIL contention_order cycle %0d got b/a gnt=%b exp %b", cyc, {bus.b_gnt, bus.a_gnt}, exp_g);
            end
            checks++;
            if (prev_strobe && bus.o_wr) begin
                failures++;
                $display("FAIL contention_spacing cycle %0d got strobe in consecutive cycles exp gap", cyc);
            end
            prev_strobe = bus.o_wr;
`ifdef REGARB_FIXED_PRIORITY_EN
            if (cyc == 7) bus.a_req = 1'b0;
`endif
        end
`ifdef REGARB_FIXED_PRIORITY_EN
        @(negedge clk);
        checks++;
        if ({bus.b_gnt, bus.a_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL fixed_b_after_a_drop got b/a gnt=%b exp 10", {bus.b_gnt, bus.a_gnt});
        end
`endif
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_held_request();
        int n_gnt;
        int n_wr;
        do_reset();
        n_gnt = 0;
        n_wr  = 0;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_reg = 2'd1; bus.a_wdata = 32'h5A5A0001;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            n_gnt += int'(bus.a_gnt);
            n_wr  += int'(bus.o_wr);
            if (cyc == 2) bus.a_req = 1'b0;
        end
        checks++;
        if (n_gnt != 1 || n_wr != 1) begin
            failures++;
            $display("FAIL held_request got gnt=%0d wr=%0d exp 1 1", n_gnt, n_wr);
        end
    endtask

    task automatic test_reset_mid_read();
        int n_rv;
        do_reset();
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_reg = 2'd1;
        @(negedge clk);
        checks++;
        if ({bus.o_rd, bus.a_gnt} !== 2'b11) begin
            failures++;
            $display("FAIL midreset_issue got rd/gnt=%b exp 11", {bus.o_rd, bus.a_gnt});
        end
        rst_n = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if ({bus.o_rd, bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL midreset_async got rd/agnt/bgnt/arv/brv=%b exp 00000",
                     {bus.o_rd, bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_rv = 0;
        repeat (3) begin
            @(negedge clk);
            n_rv += int'(bus.a_rvalid) + int'(bus.b_rvalid);
        end
        checks++;
        if (n_rv != 0) begin
            failures++;
            $display("FAIL midreset_no_rvalid got %0d rvalid pulses exp 0", n_rv);
        end
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_reg = 2'd0;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_reg = 2'd2;
        @(negedge clk);
        checks++;
        if ({bus.b_gnt, bus.a_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL midreset_next_grant got b/a gnt=%b exp 01", {bus.b_gnt, bus.a_gnt});
        end
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random(input int ncyc);
        logic [31:0] shadow [4];
        logic        req [2];
        logic        we [2];
        logic [1:0]  rg [2];
        logic [31:0] wd [2];
        logic [31:0] exp_rd [2];
        logic [31:0] held [2];
        int          wt [2];
        logic [1:0]  pend_cur, pend_nxt, gnt;
        logic [1:0]  exp_rreg, exp_wreg;
        logic [31:0] exp_wdata;
        logic        prev_g;
        int          last;
        do_reset();
        for (int i = 0; i < 4; i++) shadow[i] = 32'h0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; rg[p] = '0; wd[p] = '0;
            exp_rd[p] = '0; held[p] = '0; wt[p] = 0;
        end
        pend_cur = '0; exp_rreg = '0; exp_wreg = '0; exp_wdata = '0;
        prev_g = 1'b0; last = 1;
        for (int c = 0; c < ncyc + 20; c++) begin
            @(negedge clk);
            gnt = {bus.b_gnt, bus.a_gnt};
            checks++;
            if (gnt == 2'b11 || (bus.o_rd && bus.o_wr)) begin
                failures++;
                $display("FAIL rand_exclusive cycle %0d got gnt=%b rd=%b wr=%b exp one at most",
                         c, gnt, bus.o_rd, bus.o_wr);
            end
            checks++;
            if ((|gnt) !== (bus.o_rd | bus.o_wr) || ((|gnt) && prev_g)) begin
                failures++;
                $display("FAIL rand_strobe cycle %0d got gnt=%b strobe=%b prev_gnt=%b exp strobe with gnt, no back-to-back",
                         c, gnt, bus.o_rd | bus.o_wr, prev_g);
            end
            checks++;
            if ({bus.b_rvalid, bus.a_rvalid} !== pend_cur) begin
                failures++;
                $display("FAIL rand_rvalid cycle %0d got %b exp %b", c, {bus.b_rvalid, bus.a_rvalid}, pend_cur);
            end
            for (int p = 0; p < 2; p++) if (pend_cur[p]) held[p] = exp_rd[p];
            checks++;
            if ({bus.a_rdata, bus.b_rdata} !== {held[0], held[1]}) begin
                failures++;
                $display("FAIL rand_rdata cycle %0d got a=%h b=%h exp a=%h b=%h",
                         c, bus.a_rdata, bus.b_rdata, held[0], held[1]);
            end
            pend_nxt = '0;
            for (int p = 0; p < 2; p++) begin
                if (gnt[p]) begin
                    checks++;
                    if (!req[p]) begin
                        failures++;
                        $display("FAIL rand_unrequested cycle %0d port %0d got gnt exp no gnt", c, p);
                    end
                    if (req[1-p]) begin
                        checks++;
`ifdef REGARB_FIXED_PRIORITY_EN
                        if (p != 0) begin
`else
                        if (p == last) begin
`endif
                            failures++;
                            $display("FAIL rand_contention cycle %0d got winner %0d exp other port (last %0d)", c, p, last);
                        end
                    end
                    last = p;
                    checks++;
                    if ({bus.o_wr, bus.o_rd} !== (we[p] ? 2'b10 : 2'b01)) begin
                        failures++;
                        $display("FAIL rand_op cycle %0d got wr/rd=%b exp we=%b", c, {bus.o_wr, bus.o_rd}, we[p]);
                    end
                    if (we[p]) begin
                        exp_wreg = rg[p];
                        exp_wdata = wd[p];
                        shadow[rg[p]] = wd[p];
                    end else begin
                        exp_rreg = rg[p];
                        exp_rd[p] = shadow[rg[p]];
                        pend_nxt[p] = 1'b1;
                    end
                    req[p] = 1'b0;
                    wt[p] = 0;
                end
            end
            pend_cur = pend_nxt;
            prev_g = |gnt;
            checks++;
            if ({bus.o_rreg, bus.o_wreg, bus.o_wdata} !== {exp_rreg, exp_wreg, exp_wdata}) begin
                failures++;
                $display("FAIL rand_regside cycle %0d got rreg=%0d wreg=%0d wdata=%h exp %0d %0d %h",
                         c, bus.o_rreg, bus.o_wreg, bus.o_wdata, exp_rreg, exp_wreg, exp_wdata);
            end
            for (int p = 0; p < 2; p++) begin
                if (req[p]) begin
                    wt[p]++;
`ifndef REGARB_FIXED_PRIORITY_EN
                    checks++;
                    if (wt[p] > 4) begin
                        failures++;
                        $display("FAIL rand_wait cycle %0d port %0d got wait %0d exp <= 4", c, p, wt[p]);
                        wt[p] = 0;
                    end
`endif
                end
                if (c < ncyc) begin
                    if (!req[p] && $urandom_range(0, 2) == 0) begin
                        req[p] = 1'b1;
                        we[p]  = 1'($urandom_range(0, 1));
                        rg[p]  = 2'($urandom_range(0, 3));
                        wd[p]  = $urandom();
                        wt[p]  = 0;
                    end else if (req[p] && $urandom_range(0, 15) == 0) begin
                        req[p] = 1'b0;
                    end
                end
            end
            bus.a_req = req[0]; bus.a_we = we[0]; bus.a_reg = rg[0]; bus.a_wdata = wd[0];
            bus.b_req = req[1]; bus.b_we = we[1]; bus.b_reg = rg[1]; bus.b_wdata = wd[1];
        end
        checks++;
        if (req[0] || req[1] || pend_cur != 2'b00) begin
            failures++;
            $display("FAIL rand_drain got req=%b%b pending=%b exp all idle", req[1], req[0], pend_cur);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;
        rd_force = 1'b0;
        rd_force_val = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_held_request();
        test_reset_mid_read();
        test_random(600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
